lsu_subword: RTL
================

Name: lsu_subword

Overview:
- CPU-side load/store initiator for the word-only, single-cycle data memory (`dmem`).
- Sits in the MEM stage between the pipeline and the `memAddr`/`memWriteData`/`MemWrite`/`MemRead`/`memReadData` interface.
- Supports byte, halfword and word loads/stores. Loads extract and extend the addressed lane in the same cycle.
- Sub-word stores run as a two-cycle read-modify-write, stalling the pipeline for one cycle.

Parameters:
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data word width (fixed at 32; lane logic assumes 4 bytes).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  pipeline has a memory op this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend loads (lbu/lhu).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rdata`  out  32  extended load result.
- `stall`  out  1  hold pipeline this cycle.
- `misaligned`  out  1  access fault, no memory access issued.
- `memAddr`  out  32  word-aligned address to dmem.
- `memWriteData`  out  32  full-word write data.
- `MemWrite`  out  1  dmem write strobe.
- `MemRead`  out  1  dmem read enable.
- `memReadData`  in  32  dmem combinational read data.

Behaviour:
- One clock `clk`; `reset` is synchronous and active-high. Reset forces state IDLE and clears the latched address and merge registers to 0.
- Lane order is little-endian: `addr[1:0]`=0 selects bits 7:0, 3 selects bits 31:24. A halfword at `addr[1]`=0 is bits 15:0, else bits 31:16.
- `memAddr` is always `{req_addr[31:2],2'b00}` in IDLE, or the latched address in MERGE_WR.
- `MemRead` and `MemWrite` are never high together.
- With `req_valid`=0 in IDLE, all outputs are 0.
- Misaligned access:
  - Half with `addr[0]`=1, word with `addr[1:0]`≠0, or `req_size`=11.
  - `misaligned`=1 combinationally that cycle, `MemRead`=`MemWrite`=0, `stall`=0, `rdata`=0, state unchanged.
- Load (IDLE, aligned), zero latency:
  - `MemRead`=1; `rdata` = selected lane of `memReadData`, sign- or zero-extended per `req_unsigned` (word ignores it).
  - `stall`=0.
- Word store (IDLE): `MemWrite`=1, `memWriteData`=`req_wdata`, `stall`=0, one cycle.
- Sub-word store, state machine IDLE → MERGE_WR → IDLE:
  - IDLE cycle: `MemRead`=1, `stall`=1. Registers latch the word address and a merged word: `memReadData` with the target lane replaced by the low byte/half of `req_wdata`. Next state MERGE_WR.
  - MERGE_WR cycle: `MemWrite`=1, `memWriteData`=merged register, `memAddr`=latched address, `stall`=0. Next state IDLE.
  - MERGE_WR is driven only from latched state; request inputs are ignored, even if `req_valid` drops.
  - The pipeline holds the request stable while `stall`=1. The request presented after MERGE_WR is a new op.
- `reset` in MERGE_WR: `MemWrite` is still driven combinationally that cycle. To abort cleanly, `MemWrite` is gated by `!reset`, so no write occurs. Next cycle is IDLE with `stall`=0.
- Back-to-back sub-word stores: the next RMW read starts in the cycle after MERGE_WR and sees the previous write.
- Exactly one RMW is in flight; there is no buffering.

Decomposition:
- `lsu_pkg`:
  - size enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), state enum (IDLE, MERGE_WR).
  - functions `lane_extract(word, addr_lo, size, uns)` and `lane_merge(word, wdata, addr_lo, size)`.
- One sub-module, `lsu_lane_align`: combinational extract/merge wrapper around the package functions, instantiated once.
- The FSM and registers stay in `lsu_subword`.

Test Plan:
1. dmem word 0x10 = 0x11223344; lw 0x10 → `MemRead`=1, `memAddr`=0x10, `rdata`=0x11223344, `stall`=0.
2. Word 0x14 = 0x88224411:
   - lb 0x17 → 0xFFFFFF88.
   - lbu 0x17 → 0x00000088.
   - lh 0x16 → 0xFFFF8822.
   - lhu 0x14 → 0x00004411.
3. sb 0x11, wdata 0x000000AB, over 0x11223344:
   - Cycle 1: `MemRead`=1, `stall`=1.
   - Cycle 2: `MemWrite`=1, `memAddr`=0x10, `memWriteData`=0x1122AB44.
   - Subsequent lw 0x10 → 0x1122AB44.
4. sh 0x12, wdata 0x1234BEEF, over 0x11223344 → cycle-2 `memWriteData`=0xBEEF3344. Immediately follow with sb 0x10, wdata 0x55 → 0xBEEF3355.
5. lw 0x12, sh 0x13, `req_size`=11 → each `misaligned`=1, `MemRead`=`MemWrite`=0, `stall`=0, memory unchanged.
6. sb 0x10 with `reset` asserted in the MERGE_WR cycle → no `MemWrite` pulse, word still 0x11223344, `stall`=0 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane helpers for the sub-word load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MERGE_WR = 1'b1
    } state_e;

    // Little-endian lane select with optional sign extension; word size passes through.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size
    );
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) res[31:16] = wdata[15:0];
                else            res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_subword_lane_align.sv
// rtl/lsu_subword_lane_align.sv - combinational load extract and store merge lanes
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ld_data,
    output logic [31:0] mg_data
);

    always_comb begin
        ld_data = lane_extract(rd_word, addr_lo, size, uns);
        mg_data = lane_merge(rd_word, wdata, addr_lo, size);
    end

endmodule

// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - MEM-stage load/store initiator with sub-word read-modify-write
module lsu_subword
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              misaligned,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] memReadData
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] merge_q, merge_d;

    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] mg_data;
    logic              bad_align;
    logic [ADDR_W-1:0] word_addr;

    lsu_lane_align u_align (
        .rd_word (memReadData),
        .wdata   (req_wdata),
        .addr_lo (req_addr[1:0]),
        .size    (req_size),
        .uns     (req_unsigned),
        .ld_data (ld_data),
        .mg_data (mg_data)
    );

    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    assign bad_align = (req_size == 2'b11)
                     || (req_size == SZ_HALF && req_addr[0])
                     || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        merge_d      = merge_q;
        rdata        = '0;
        stall        = 1'b0;
        misaligned   = 1'b0;
        memAddr      = '0;
        memWriteData = '0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    memAddr = word_addr;
                    if (bad_align) begin
                        misaligned = 1'b1;
                    end else if (!req_write) begin
                        MemRead = 1'b1;
                        rdata   = ld_data;
                    end else if (req_size == SZ_WORD) begin
                        MemWrite     = 1'b1;
                        memWriteData = req_wdata;
                    end else begin
                        MemRead = 1'b1;
                        stall   = 1'b1;
                        addr_d  = word_addr;
                        merge_d = mg_data;
                        state_d = MERGE_WR;
                    end
                end
            end
            MERGE_WR: begin
                // Only latched state drives this cycle; a reset here suppresses the write.
                MemWrite     = !reset;
                memWriteData = merge_q;
                memAddr      = addr_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            merge_q <= merge_d;
        end
    end

endmodule
